// File: rtl/zr_bus_arbiter.sv
// zr_bus_arbiter: arbitrates the core fetch port and load/store port onto a
// single Wishbone master. One transaction is outstanding at a time; when both
// ports request together, the port not granted last wins.
// Optional feature: define ZR_ARB_TIMEOUT_EN to add a bus-cycle watchdog that
// ends a stalled Wishbone cycle after TIMEOUT_CYCLES clocks with an error response.
//
// state | meaning
// IDLE  | no transaction; winning requester is granted in the same cycle
// BUS   | Wishbone cycle active with latched fields, waiting for ack
// RESP  | single rvalid cycle on the port that owns the transaction
module zr_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("zr_bus_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_q, state_d;
    logic        last_data_q;   // 1 when the data port holds the most recent grant
    logic        own_data_q;    // 1 when the current transaction belongs to the data port
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q, dat_q;
    logic [31:0] instr_rdata_q, data_rdata_q;
    logic        grant_instr, grant_data;
    logic        timeout, bus_done;

    // Arbitration: lone requester wins, a tie goes to the port not granted last
    always_comb begin
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (instr_req_i && (!data_req_i || last_data_q))
                grant_instr = 1'b1;
            else if (data_req_i)
                grant_data = 1'b1;
        end
    end

`ifdef ZR_ARB_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog_q;
    logic        err_q;

    // Watchdog counts unacknowledged BUS cycles, zero whenever outside BUS
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            wdog_q <= '0;
        else if (state_q != ST_BUS)
            wdog_q <= '0;
        else if (!wb_ack_i)
            wdog_q <= wdog_q + 16'd1;
    end

    assign timeout = (state_q == ST_BUS) && !wb_ack_i && (wdog_q == WDOG_LAST);

    // Error flag for the response cycle; only a data-port timeout reports it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            err_q <= 1'b0;
        else if (bus_done)
            err_q <= timeout && own_data_q;
    end

    assign data_err_o = data_rvalid_o && err_q;
`else
    assign timeout    = 1'b0;
    assign data_err_o = 1'b0;
`endif

    assign bus_done = (state_q == ST_BUS) && (wb_ack_i || timeout);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_instr || grant_data) state_d = ST_BUS;
            ST_BUS:  if (bus_done) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and arbitration result
    always_comb begin
        instr_gnt_o    = grant_instr;
        data_gnt_o     = grant_data;
        wb_cyc_o       = (state_q == ST_BUS);
        wb_stb_o       = (state_q == ST_BUS);
        instr_rvalid_o = (state_q == ST_RESP) && !own_data_q;
        data_rvalid_o  = (state_q == ST_RESP) && own_data_q;
    end

    // Latch the winner's request fields at the grant edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_data_q <= 1'b1;
            own_data_q  <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else if (grant_instr) begin
            last_data_q <= 1'b0;
            own_data_q  <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'hF;
            adr_q       <= instr_addr_i;
            dat_q       <= '0;
        end else if (grant_data) begin
            last_data_q <= 1'b1;
            own_data_q  <= 1'b1;
            we_q        <= data_we_i;
            sel_q       <= data_be_i;
            adr_q       <= data_addr_i;
            dat_q       <= data_wdata_i;
        end
    end

    // Capture the response for the owning port; writes return zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else if (bus_done) begin
            if (own_data_q)
                data_rdata_q <= timeout ? 32'hDEADBEEF : (we_q ? 32'h0 : wb_dat_i);
            else
                instr_rdata_q <= timeout ? 32'hDEADBEEF : wb_dat_i;
        end
    end

    assign wb_we_o       = we_q;
    assign wb_sel_o      = sel_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign instr_rdata_o = instr_rdata_q;
    assign data_rdata_o  = data_rdata_q;

endmodule

// File: tb/tb_zr_bus_arbiter.sv
// Self-checking bench for zr_bus_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level scoreboard.
module tb_zr_bus_arbiter;
`ifdef ZR_ARB_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;

    int total = 0;
    int bad   = 0;

    zr_bus_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL sim_timeout: simulation did not finish, got t=%0t need <500000", $time);
        $fatal(1, "bench time limit exceeded");
    end

    task automatic clear_inputs();
        instr_req_i = 0; instr_addr_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        wb_ack_i = 0; wb_dat_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    // start of a cycle: just after the rising edge
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 0;
        #3;
        total++;
        if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, data_err_o} !== 5'b0) begin
            bad++; $display("FAIL rst_handshake got=%b need=00000",
                {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, data_err_o});
        end
        total++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b0 || wb_sel_o !== 4'h0) begin
            bad++; $display("FAIL rst_wb_ctrl got cyc=%b stb=%b we=%b sel=%h need 0", wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o);
        end
        total++;
        if (wb_adr_o !== 0 || wb_dat_o !== 0 || instr_rdata_o !== 0 || data_rdata_o !== 0) begin
            bad++; $display("FAIL rst_regs got adr=%h dat=%h ir=%h dr=%h need 0", wb_adr_o, wb_dat_o, instr_rdata_o, data_rdata_o);
        end
        do_reset();
    endtask

    task automatic test_instr_read();
        do_reset();
        next_cycle(); instr_req_i = 1; instr_addr_i = 32'h100;
        @(negedge clk_i);
        total++;
        if (instr_gnt_o !== 1 || data_gnt_o !== 0) begin
            bad++; $display("FAIL ird_gnt got i=%b d=%b need i=1 d=0", instr_gnt_o, data_gnt_o);
        end
        next_cycle(); instr_req_i = 0; wb_ack_i = 1; wb_dat_i = 32'h00000013;
        @(negedge clk_i);
        total++;
        if (wb_cyc_o !== 1 || wb_stb_o !== 1 || wb_adr_o !== 32'h100 || wb_we_o !== 0 || wb_sel_o !== 4'hF) begin
            bad++; $display("FAIL ird_bus got cyc=%b stb=%b adr=%h we=%b sel=%h need 1 1 100 0 f",
                wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_sel_o);
        end
        next_cycle(); wb_ack_i = 0; wb_dat_i = 32'h0;
        @(negedge clk_i);
        total++;
        if (instr_rvalid_o !== 1 || instr_rdata_o !== 32'h13 || wb_stb_o !== 0 || data_rvalid_o !== 0) begin
            bad++; $display("FAIL ird_resp got rv=%b rd=%h stb=%b drv=%b need 1 00000013 0 0",
                instr_rvalid_o, instr_rdata_o, wb_stb_o, data_rvalid_o);
        end
        next_cycle();
        @(negedge clk_i);
        total++;
        if (instr_rvalid_o !== 0 || instr_rdata_o !== 32'h13) begin
            bad++; $display("FAIL ird_hold got rv=%b rd=%h need 0 00000013", instr_rvalid_o, instr_rdata_o);
        end
    endtask

    task automatic test_data_write();
        do_reset();
        next_cycle();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011; data_addr_i = 32'h2000; data_wdata_i = 32'hCAFEF00D;
        @(negedge clk_i);
        total++;
        if (data_gnt_o !== 1 || instr_gnt_o !== 0) begin
            bad++; $display("FAIL dwr_gnt got d=%b i=%b need d=1 i=0", data_gnt_o, instr_gnt_o);
        end
        next_cycle(); data_req_i = 0; data_wdata_i = 0; wb_ack_i = 1; wb_dat_i = 32'h12345678;
        @(negedge clk_i);
        total++;
        if (wb_stb_o !== 1 || wb_we_o !== 1 || wb_sel_o !== 4'b0011 || wb_adr_o !== 32'h2000 || wb_dat_o !== 32'hCAFEF00D) begin
            bad++; $display("FAIL dwr_bus got stb=%b we=%b sel=%b adr=%h dat=%h need 1 1 0011 2000 cafef00d",
                wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
        end
        next_cycle(); wb_ack_i = 0;
        @(negedge clk_i);
        total++;
        if (data_rvalid_o !== 1 || data_rdata_o !== 32'h0 || data_err_o !== 0) begin
            bad++; $display("FAIL dwr_resp got rv=%b rd=%h err=%b need 1 0 0", data_rvalid_o, data_rdata_o, data_err_o);
        end
    endtask

    task automatic test_round_robin();
        bit want_d;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            instr_req_i = 1; instr_addr_i = 32'h400; data_req_i = 1; data_we_i = 0; data_addr_i = 32'h800;
            wb_ack_i = 1; wb_dat_i = c;
            @(negedge clk_i);
            total++;
            if (c % 3 == 0) begin
                want_d = ((c / 3) % 2) == 1;
                if (instr_gnt_o !== !want_d || data_gnt_o !== want_d) begin
                    bad++; $display("FAIL rr_grant c=%0d got i=%b d=%b need i=%b d=%b",
                        c, instr_gnt_o, data_gnt_o, !want_d, want_d);
                end
            end else if (instr_gnt_o !== 0 || data_gnt_o !== 0) begin
                bad++; $display("FAIL rr_nogrant c=%0d got i=%b d=%b need 0 0", c, instr_gnt_o, data_gnt_o);
            end
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        next_cycle(); instr_req_i = 1; instr_addr_i = 32'h300; data_req_i = 1; data_addr_i = 32'h900;
        @(negedge clk_i);
        total++;
        if (instr_gnt_o !== 1 || data_gnt_o !== 0) begin
            bad++; $display("FAIL dly_gnt got i=%b d=%b need 1 0", instr_gnt_o, data_gnt_o);
        end
        for (int c = 1; c <= 5; c++) begin
            next_cycle(); instr_req_i = 0; instr_addr_i = 32'hFFF0;
            wb_ack_i = (c == 5); wb_dat_i = 32'hA5A50000 + c;
            @(negedge clk_i);
            total++;
            if (wb_cyc_o !== 1 || wb_stb_o !== 1 || wb_adr_o !== 32'h300 || data_gnt_o !== 0) begin
                bad++; $display("FAIL dly_bus c=%0d got cyc=%b stb=%b adr=%h dgnt=%b need 1 1 300 0",
                    c, wb_cyc_o, wb_stb_o, wb_adr_o, data_gnt_o);
            end
        end
        next_cycle(); wb_ack_i = 0;
        @(negedge clk_i);
        total++;
        if (instr_rvalid_o !== 1 || instr_rdata_o !== 32'hA5A50005 || data_gnt_o !== 0) begin
            bad++; $display("FAIL dly_resp got rv=%b rd=%h dgnt=%b need 1 a5a50005 0", instr_rvalid_o, instr_rdata_o, data_gnt_o);
        end
        next_cycle();
        @(negedge clk_i);
        total++;
        if (data_gnt_o !== 1) begin
            bad++; $display("FAIL dly_pending got dgnt=%b need 1", data_gnt_o);
        end
    endtask

`ifdef ZR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        next_cycle(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h44;
        @(negedge clk_i);
        for (int c = 1; c <= 4; c++) begin
            next_cycle(); data_req_i = 0;
            @(negedge clk_i);
            total++;
            if (wb_cyc_o !== 1 || data_rvalid_o !== 0) begin
                bad++; $display("FAIL tmo_bus c=%0d got cyc=%b rv=%b need 1 0", c, wb_cyc_o, data_rvalid_o);
            end
        end
        next_cycle();
        @(negedge clk_i);
        total++;
        if (wb_cyc_o !== 0 || wb_stb_o !== 0 || data_rvalid_o !== 1 || data_rdata_o !== 32'hDEADBEEF || data_err_o !== 1) begin
            bad++; $display("FAIL tmo_resp got cyc=%b stb=%b rv=%b rd=%h err=%b need 0 0 1 deadbeef 1",
                wb_cyc_o, wb_stb_o, data_rvalid_o, data_rdata_o, data_err_o);
        end
        next_cycle(); data_req_i = 1; data_addr_i = 32'h48;
        @(negedge clk_i);
        total++;
        if (data_gnt_o !== 1 || data_err_o !== 0) begin
            bad++; $display("FAIL tmo_regnt got gnt=%b err=%b need 1 0", data_gnt_o, data_err_o);
        end
        next_cycle(); data_req_i = 0; wb_ack_i = 1; wb_dat_i = 32'h55;
        @(negedge clk_i);
        next_cycle(); wb_ack_i = 0;
        @(negedge clk_i);
        total++;
        if (data_rvalid_o !== 1 || data_rdata_o !== 32'h55 || data_err_o !== 0) begin
            bad++; $display("FAIL tmo_after got rv=%b rd=%h err=%b need 1 00000055 0", data_rvalid_o, data_rdata_o, data_err_o);
        end
    endtask
`else
    task automatic test_no_timeout();
        int stuck = 0;
        do_reset();
        next_cycle(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h40;
        @(negedge clk_i);
        for (int c = 1; c <= 300; c++) begin
            next_cycle(); data_req_i = 0;
            @(negedge clk_i);
            if (wb_stb_o === 1 && data_rvalid_o === 0 && data_err_o === 0) stuck++;
        end
        total++;
        if (stuck != 300) begin
            bad++; $display("FAIL nowd_wait got waiting_cycles=%0d need 300", stuck);
        end
        next_cycle(); wb_ack_i = 1; wb_dat_i = 32'h0BADF00D;
        @(negedge clk_i);
        next_cycle(); wb_ack_i = 0;
        @(negedge clk_i);
        total++;
        if (data_rvalid_o !== 1 || data_rdata_o !== 32'h0BADF00D || data_err_o !== 0) begin
            bad++; $display("FAIL nowd_resp got rv=%b rd=%h err=%b need 1 0badf00d 0", data_rvalid_o, data_rdata_o, data_err_o);
        end
    endtask
`endif

    task automatic test_reset_in_bus();
        int rv_seen = 0;
        do_reset();
        next_cycle(); instr_req_i = 1; instr_addr_i = 32'h10;
        @(negedge clk_i);
        next_cycle(); instr_req_i = 0; wb_ack_i = 1; wb_dat_i = 32'h77;
        @(negedge clk_i);
        next_cycle(); wb_ack_i = 0;
        @(negedge clk_i);
        next_cycle(); data_req_i = 1; data_addr_i = 32'h20;
        @(negedge clk_i);
        next_cycle(); data_req_i = 0;
        @(negedge clk_i);
        total++;
        if (wb_stb_o !== 1) begin
            bad++; $display("FAIL rib_pre got stb=%b need 1", wb_stb_o);
        end
        next_cycle(); wb_ack_i = 1; wb_dat_i = 32'h99;
        #2 rst_ni = 0;
        #1;
        total++;
        if (wb_cyc_o !== 0 || wb_stb_o !== 0) begin
            bad++; $display("FAIL rib_abort got cyc=%b stb=%b need 0 0", wb_cyc_o, wb_stb_o);
        end
        @(negedge clk_i);
        if (data_rvalid_o !== 0 || instr_rvalid_o !== 0) rv_seen++;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1; wb_ack_i = 0;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk_i);
            if (data_rvalid_o !== 0 || instr_rvalid_o !== 0) rv_seen++;
        end
        total++;
        if (rv_seen != 0) begin
            bad++; $display("FAIL rib_norv got rvalid_cycles=%0d need 0", rv_seen);
        end
        next_cycle(); instr_req_i = 1; data_req_i = 1;
        @(negedge clk_i);
        total++;
        if (instr_gnt_o !== 1 || data_gnt_o !== 0) begin
            bad++; $display("FAIL rib_tie got i=%b d=%b need 1 0", instr_gnt_o, data_gnt_o);
        end
    endtask

    task automatic test_random();
        bit          i_pend = 0, d_pend = 0, d_we = 0;
        logic [31:0] i_adr = 0, d_adr = 0, d_wd = 0;
        logic [3:0]  d_be = 0;
        int          phase = 0;   // 0 free, 1 on bus, 2 responding
        bit          own_d = 0, last_d = 1, exp_gi, exp_gd;
        logic [31:0] t_adr = 0, t_wd = 0, resp_val = 0, exp_ir = 0, exp_dr = 0;
        logic        t_we = 0;
        logic [3:0]  t_sel = 0;
        int          ack_after = 1, bus_cnt = 0, n_txn = 0;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            next_cycle();
            if (!i_pend && $urandom_range(2) == 0) begin
                i_pend = 1; i_adr = $urandom;
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1; d_adr = $urandom; d_wd = $urandom;
                d_we = 1'($urandom_range(1)); d_be = 4'($urandom_range(15));
            end
            instr_req_i = i_pend; instr_addr_i = i_adr;
            data_req_i = d_pend; data_addr_i = d_adr; data_wdata_i = d_wd; data_we_i = d_we; data_be_i = d_be;
            wb_dat_i = $urandom;
            if (phase == 1) begin
                bus_cnt++;
                wb_ack_i = (bus_cnt >= ack_after);
            end else begin
                wb_ack_i = ($urandom_range(3) == 0);
            end
            @(negedge clk_i);
            exp_gi = 0; exp_gd = 0;
            if (phase == 0 && (i_pend || d_pend)) begin
                if (i_pend && d_pend) begin
                    exp_gi = last_d; exp_gd = !last_d;
                end else begin
                    exp_gi = i_pend; exp_gd = d_pend;
                end
            end
            if (phase == 2) begin
                if (own_d) exp_dr = resp_val; else exp_ir = resp_val;
            end
            total++;
            if (instr_gnt_o !== exp_gi || data_gnt_o !== exp_gd) begin
                bad++; $display("FAIL rnd_gnt cyc=%0d got i=%b d=%b need i=%b d=%b", cyc, instr_gnt_o, data_gnt_o, exp_gi, exp_gd);
            end
            total++;
            if (wb_cyc_o !== (phase == 1) || wb_stb_o !== (phase == 1)) begin
                bad++; $display("FAIL rnd_cycstb cyc=%0d got cyc=%b stb=%b need %b", cyc, wb_cyc_o, wb_stb_o, phase == 1);
            end
            if (phase == 1) begin
                total++;
                if (wb_adr_o !== t_adr || wb_we_o !== t_we || wb_sel_o !== t_sel || (t_we && wb_dat_o !== t_wd)) begin
                    bad++; $display("FAIL rnd_fields cyc=%0d got adr=%h we=%b sel=%h dat=%h need %h %b %h %h",
                        cyc, wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o, t_adr, t_we, t_sel, t_wd);
                end
            end
            total++;
            if (instr_rvalid_o !== (phase == 2 && !own_d) || data_rvalid_o !== (phase == 2 && own_d)) begin
                bad++; $display("FAIL rnd_rvalid cyc=%0d got i=%b d=%b need i=%b d=%b",
                    cyc, instr_rvalid_o, data_rvalid_o, phase == 2 && !own_d, phase == 2 && own_d);
            end
            total++;
            if (instr_rdata_o !== exp_ir || data_rdata_o !== exp_dr || data_err_o !== 0) begin
                bad++; $display("FAIL rnd_rdata cyc=%0d got i=%h d=%h err=%b need i=%h d=%h err=0",
                    cyc, instr_rdata_o, data_rdata_o, data_err_o, exp_ir, exp_dr);
            end
            if (phase == 0 && (exp_gi || exp_gd)) begin
                phase = 1; own_d = exp_gd; last_d = exp_gd; bus_cnt = 0; ack_after = $urandom_range(1, 3);
                n_txn++;
                if (exp_gd) begin
                    t_adr = d_adr; t_we = d_we; t_sel = d_be; t_wd = d_wd; d_pend = 0;
                end else begin
                    t_adr = i_adr; t_we = 0; t_sel = 4'hF; t_wd = 0; i_pend = 0;
                end
            end else if (phase == 1 && wb_ack_i) begin
                phase = 2;
                resp_val = (own_d && t_we) ? 32'h0 : wb_dat_i;
            end else if (phase == 2) begin
                phase = 0;
            end
        end
        total++;
        if (n_txn < 100) begin
            bad++; $display("FAIL rnd_throughput got txns=%0d need >=100", n_txn);
        end
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_data_write();
        test_round_robin();
        test_ack_delay();
`ifdef ZR_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_in_bus();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
